nextpc_unit: RTL and testbench
==============================

# nextpc_unit

Parametrised, registered program-counter unit for the pipelined LEGv8 core. It replaces the combinational next-PC adder with a PC register that handshakes with instruction fetch. It resolves conditional, unconditional and register branches arriving from execute, and traps misaligned targets to an exception vector. An optional return-address stack serves `RET` targets.

## Interface
Parameters:
- `ADDR_W`, 64, PC/immediate width.
- `RESET_PC`, 0, PC value loaded at reset.
- `EXC_VECTOR`, 64'h100, PC after a misaligned-target fault.
- `IMM_SHIFT`, 0, left shift applied to `SignExtImm` before the add (2 for word offsets).
- `RAS_DEPTH`, 4, return-stack entries (power of two, ≥2).

Ports:
- `CLK` in 1: clock.
- `resetl` in 1: asynchronous, active-low reset.
- `pc` out ADDR_W: current fetch address.
- `pc_valid` out 1: `pc` is offered to fetch.
- `pc_ready` in 1: fetch accepts `pc` this cycle.
- `br_valid` in 1: execute presents a resolved control instruction.
- `br_pc` in ADDR_W: PC of that instruction.
- `SignExtImm` in ADDR_W: sign-extended offset.
- `Branch`, `ALUZero`, `Uncondbranch` in 1 each: same meaning as the legacy next-PC logic.
- `BranchReg` in 1: `BR`/`RET`; the target is `reg_target`.
- `reg_target` in ADDR_W: register-sourced target.
- `is_link` in 1: `BL`; push `br_pc+4` (RAS builds only).
- `is_ret` in 1: `RET` (RAS builds only).
- `flush` out 1: one-cycle pulse on any taken redirect.
- `fault` out 1: high while in HALT.
- `fault_ack` in 1: leave HALT.

## Operation
- Taken = `br_valid & (Uncondbranch | BranchReg | (Branch & ALUZero))`.
- Target when `BranchReg` is set: `reg_target`.
- Target otherwise: `br_pc + (SignExtImm << IMM_SHIFT)`, modulo 2^ADDR_W, wrap silent.
- States:
  - BOOT: first cycle after reset release; `pc_valid`=0; then RUN.
  - RUN: `pc_valid`=1.
  - HALT: `pc_valid`=0, `fault`=1.
- In RUN, priority is highest first:
  1. Taken with `target[1:0]≠0`: `pc`←`EXC_VECTOR`, `flush`=1, go to HALT.
  2. Taken, aligned: `pc`←target, `flush`=1.
  3. `pc_ready`: `pc`←`pc+4`.
  4. Otherwise hold.
- A redirect overrides an accepted fetch in the same cycle; the accepted `pc` is discarded by `flush`.
- Not-taken `br_valid` has no effect.
- HALT→RUN on `fault_ack`. Branch inputs are ignored in BOOT and HALT.
- `fault_ack` is ignored outside HALT.

## Timing
- Reset values: `pc`=`RESET_PC`, `pc_valid`=0, `flush`=0, `fault`=0, state=BOOT, RAS empty.
- Reset asserted mid-operation returns everything to these values immediately.
- Redirect latency: the target appears on `pc` the cycle after `br_valid`. `flush` is registered and coincides with the new `pc`.
- `pc` and `pc_valid` are stable while `pc_valid & ~pc_ready`, unless a redirect occurs.
- Back-to-back redirects on consecutive cycles are each honoured; the last one wins.

## Configuration
- `NEXTPC_RAS_EN` defined:
  - `is_link & taken` pushes `br_pc+4`.
  - `is_ret & taken` pops; when non-empty, the popped value replaces `reg_target` as the target.
  - When empty, `reg_target` is used.
  - A push when full overwrites the oldest entry (circular).
  - Simultaneous `is_link` and `is_ret`: pop, then push.
  - RAS is untouched on a fault.
- Not defined: `is_link`/`is_ret` are ignored, no RAS storage is built, and `BranchReg` always uses `reg_target`.

## Structure
- Package `nextpc_pkg`:
  - state enum (`PCS_BOOT`, `PCS_RUN`, `PCS_HALT`);
  - `INSN_BYTES`=4.
- Sub-module `nextpc_ras`: circular stack with push/pop/top/empty, parametrised by `ADDR_W` and `RAS_DEPTH`. It is instantiated only under `NEXTPC_RAS_EN`.

## Test plan
- Reset, then `pc_ready`=1 for 4 cycles → BOOT cycle, then `pc` = 0, 4, 8, 12 with `pc_valid`=1.
- `pc`=0x40, `pc_ready`=0 for 3 cycles → `pc` holds at 0x40 with `pc_valid`=1.
- `br_pc`=0x1000, `SignExtImm`=0xFFFF_FFFF_FFFF_FFF0, `Branch`=1, `ALUZero`=1, `pc_ready`=1 → next `pc`=0xFF0, `flush`=1 for one cycle.
- Same inputs with `ALUZero`=0 → no redirect, `pc`+4.
- `Uncondbranch`=1, target 0x1002 → `pc`=`EXC_VECTOR`, `fault`=1, `pc_valid`=0. `fault_ack` → RUN, fetch resumes from `EXC_VECTOR`.
- `NEXTPC_RAS_EN` build:
  - `BL` at 0x200, then `BL` at 0x300 → RAS holds 0x204, 0x304.
  - `RET` with `reg_target`=0 → `pc`=0x304; second `RET` → `pc`=0x204.
  - Third `RET` → `pc`=`reg_target`.
  - Push overflow at depth+1 `BL`s drops the oldest entry.

Source files
------------

// File: rtl/nextpc_pkg.sv
// Shared types and constants for the registered next-PC unit.
package nextpc_pkg;

   typedef enum logic [1:0] {
      PCS_BOOT = 2'd0,
      PCS_RUN  = 2'd1,
      PCS_HALT = 2'd2
   } pc_state_t;

   localparam int INSN_BYTES = 4;

endpackage : nextpc_pkg

// File: rtl/nextpc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry;
// a simultaneous pop and push replaces the top entry in place.
module nextpc_ras #(
   parameter int ADDR_W    = 64,
   parameter int RAS_DEPTH = 4
) (
   input  logic              CLK,
   input  logic              resetl,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_data,
   output logic [ADDR_W-1:0] top,
   output logic              empty
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(RAS_DEPTH);

   logic [ADDR_W-1:0] mem [RAS_DEPTH];
   logic [PTR_W-1:0]  sp_reg;
   logic [PTR_W:0]    count_reg;
   logic [PTR_W-1:0]  top_idx;
   logic              pop_eff;

   assign top_idx = sp_reg - 1'b1;
   assign empty   = (count_reg == '0);
   assign top     = mem[top_idx];
   assign pop_eff = pop & ~empty;

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         sp_reg    <= '0;
         count_reg <= '0;
      end else if (push && !pop_eff) begin
         sp_reg <= sp_reg + 1'b1;
         if (count_reg != FULL_COUNT)
            count_reg <= count_reg + 1'b1;
      end else if (pop_eff && !push) begin
         sp_reg    <= top_idx;
         count_reg <= count_reg - 1'b1;
      end
   end

   // Pop-then-push lands on the slot just vacated, i.e. the old top.
   always_ff @(posedge CLK) begin
      if (push)
         mem[pop_eff ? top_idx : sp_reg] <= push_data;
   end

endmodule : nextpc_ras

// File: rtl/nextpc_unit.sv
// Registered PC with fetch handshake, branch redirect and misaligned-target trap.
// Define NEXTPC_RAS_EN to build the return-address stack that serves RET targets.
module nextpc_unit
   import nextpc_pkg::*;
#(
   parameter int                ADDR_W     = 64,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0,
   parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(64'h100),
   parameter int                IMM_SHIFT  = 0,
   parameter int                RAS_DEPTH  = 4
) (
   input  logic              CLK,
   input  logic              resetl,
   output logic [ADDR_W-1:0] pc,
   output logic              pc_valid,
   input  logic              pc_ready,
   input  logic              br_valid,
   input  logic [ADDR_W-1:0] br_pc,
   input  logic [ADDR_W-1:0] SignExtImm,
   input  logic              Branch,
   input  logic              ALUZero,
   input  logic              Uncondbranch,
   input  logic              BranchReg,
   input  logic [ADDR_W-1:0] reg_target,
   input  logic              is_link,
   input  logic              is_ret,
   output logic              flush,
   output logic              fault,
   input  logic              fault_ack
);

   pc_state_t         state_reg, state_next;
   logic [ADDR_W-1:0] pc_reg, pc_next;
   logic              flush_reg, flush_next;

   logic              taken;
   logic              misaligned;
   logic [ADDR_W-1:0] rel_target;
   logic [ADDR_W-1:0] reg_sel;
   logic [ADDR_W-1:0] target;

   assign taken      = br_valid & (Uncondbranch | BranchReg | (Branch & ALUZero));
   assign rel_target = br_pc + (SignExtImm << IMM_SHIFT);
   assign target     = BranchReg ? reg_sel : rel_target;
   assign misaligned = |target[1:0];

`ifdef NEXTPC_RAS_EN
   logic [ADDR_W-1:0] ras_top;
   logic              ras_empty;
   logic              ras_commit;

   // The stack only moves on a redirect that actually takes effect.
   assign ras_commit = (state_reg == PCS_RUN) & taken & ~misaligned;
   assign reg_sel    = (is_ret & ~ras_empty) ? ras_top : reg_target;

   nextpc_ras #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .CLK       (CLK),
      .resetl    (resetl),
      .push      (ras_commit & is_link),
      .pop       (ras_commit & is_ret),
      .push_data (br_pc + ADDR_W'(INSN_BYTES)),
      .top       (ras_top),
      .empty     (ras_empty)
   );
`else
   logic unused_ras;
   assign unused_ras = is_link ^ is_ret;
   assign reg_sel    = reg_target;
`endif

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         state_reg <= PCS_BOOT;
         pc_reg    <= RESET_PC;
         flush_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         flush_reg <= flush_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      flush_next = 1'b0;
      unique case (state_reg)
         PCS_BOOT: state_next = PCS_RUN;
         PCS_RUN: begin
            if (taken && misaligned) begin
               pc_next    = EXC_VECTOR;
               flush_next = 1'b1;
               state_next = PCS_HALT;
            end else if (taken) begin
               pc_next    = target;
               flush_next = 1'b1;
            end else if (pc_ready) begin
               pc_next = pc_reg + ADDR_W'(INSN_BYTES);
            end
         end
         PCS_HALT: begin
            if (fault_ack)
               state_next = PCS_RUN;
         end
         default: state_next = PCS_BOOT;
      endcase
   end

   assign pc       = pc_reg;
   assign pc_valid = (state_reg == PCS_RUN);
   assign fault    = (state_reg == PCS_HALT);
   assign flush    = flush_reg;

endmodule : nextpc_unit

// File: tb/tb_nextpc_unit.sv
// Self-checking bench for nextpc_unit: directed plan plus randomized traffic
// against a queue-based behavioural model; follows NEXTPC_RAS_EN like the RTL.
module tb_nextpc_unit;

   localparam int          ADDR_W     = 64;
   localparam logic [63:0] RESET_PC   = 64'h0;
   localparam logic [63:0] EXC_VECTOR = 64'h100;
   localparam int          IMM_SHIFT  = 0;
   localparam int          RAS_DEPTH  = 4;

   logic        CLK = 1'b0;
   logic        resetl = 1'b0;
   logic [63:0] pc;
   logic        pc_valid;
   logic        pc_ready = 1'b0;
   logic        br_valid = 1'b0;
   logic [63:0] br_pc = '0;
   logic [63:0] SignExtImm = '0;
   logic        Branch = 1'b0, ALUZero = 1'b0, Uncondbranch = 1'b0, BranchReg = 1'b0;
   logic [63:0] reg_target = '0;
   logic        is_link = 1'b0, is_ret = 1'b0;
   logic        flush, fault;
   logic        fault_ack = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   nextpc_unit #(
      .ADDR_W     (ADDR_W),
      .RESET_PC   (RESET_PC),
      .EXC_VECTOR (EXC_VECTOR),
      .IMM_SHIFT  (IMM_SHIFT),
      .RAS_DEPTH  (RAS_DEPTH)
   ) dut (
      .CLK          (CLK),
      .resetl       (resetl),
      .pc           (pc),
      .pc_valid     (pc_valid),
      .pc_ready     (pc_ready),
      .br_valid     (br_valid),
      .br_pc        (br_pc),
      .SignExtImm   (SignExtImm),
      .Branch       (Branch),
      .ALUZero      (ALUZero),
      .Uncondbranch (Uncondbranch),
      .BranchReg    (BranchReg),
      .reg_target   (reg_target),
      .is_link      (is_link),
      .is_ret       (is_ret),
      .flush        (flush),
      .fault        (fault),
      .fault_ack    (fault_ack)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_mode  = 0;        // 0 boot, 1 run, 2 halted
   logic [63:0] m_pc    = RESET_PC;
   logic        m_flush = 1'b0;
   logic [63:0] m_ras[$];

   always @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         m_mode  = 0;
         m_pc    = RESET_PC;
         m_flush = 1'b0;
         m_ras.delete();
      end else begin
         bit          tk, ret_hit;
         logic [63:0] tgt;
         m_flush = 1'b0;
         if (m_mode == 0) begin
            m_mode = 1;
         end else if (m_mode == 2) begin
            if (fault_ack) m_mode = 1;
         end else begin
            tk = br_valid && (Uncondbranch || BranchReg || (Branch && ALUZero));
            ret_hit = 1'b0;
`ifdef NEXTPC_RAS_EN
            ret_hit = is_ret && (m_ras.size() > 0);
`endif
            if (BranchReg) tgt = ret_hit ? m_ras[$] : reg_target;
            else           tgt = br_pc + (SignExtImm << IMM_SHIFT);
            if (tk && (tgt % 4 != 0)) begin
               m_pc = EXC_VECTOR; m_flush = 1'b1; m_mode = 2;
            end else if (tk) begin
`ifdef NEXTPC_RAS_EN
               if (ret_hit) void'(m_ras.pop_back());
               if (is_link) begin
                  m_ras.push_back(br_pc + 64'd4);
                  if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
               end
`endif
               m_pc = tgt; m_flush = 1'b1;
            end else if (pc_ready) begin
               m_pc = m_pc + 64'd4;
            end
         end
      end
   end

   // Compare DUT against the model on every falling edge.
   always @(negedge CLK) begin
      check("model_pc", pc, m_pc);
      check("model_pc_valid", pc_valid, (m_mode == 1));
      check("model_flush", flush, m_flush);
      check("model_fault", fault, (m_mode == 2));
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_br();
      br_valid = 0; Branch = 0; ALUZero = 0; Uncondbranch = 0; BranchReg = 0;
      is_link = 0; is_ret = 0; fault_ack = 0;
   endtask

   task automatic txn(input string name, input logic [63:0] exp_pc, input logic exp_valid,
                      input logic exp_flush, input logic exp_fault);
      step();
      $display("txn %s: pc=0x%0h valid=%0b flush=%0b fault=%0b", name, pc, pc_valid, flush, fault);
      check({name, "_pc"}, pc, exp_pc);
      check({name, "_valid"}, pc_valid, exp_valid);
      check({name, "_flush"}, flush, exp_flush);
      check({name, "_fault"}, fault, exp_fault);
   endtask

   task automatic set_rel(input logic [63:0] bpc, input logic [63:0] imm);
      br_valid = 1; Uncondbranch = 1; br_pc = bpc; SignExtImm = imm;
   endtask

   task automatic set_ret(input logic [63:0] rt);
      br_valid = 1; BranchReg = 1; is_ret = 1; reg_target = rt;
   endtask

   initial begin
      logic [63:0] exp;
      repeat (3) step();
      check("reset_pc", pc, RESET_PC);
      check("reset_valid", pc_valid, 1'b0);
      check("reset_flush", flush, 1'b0);
      check("reset_fault", fault, 1'b0);
      resetl = 1; pc_ready = 1;
      #1 check("boot_valid", pc_valid, 1'b0);
      for (int i = 0; i < 4; i++) txn("seq", 64'(4 * i), 1, 0, 0);

      set_rel(64'h30, 64'h10); pc_ready = 0;
      txn("redir40", 64'h40, 1, 1, 0);
      clear_br();
      for (int i = 0; i < 3; i++) txn("hold40", 64'h40, 1, 0, 0);

      pc_ready = 1; br_valid = 1; Branch = 1; ALUZero = 1;
      br_pc = 64'h1000; SignExtImm = 64'hFFFF_FFFF_FFFF_FFF0;
      txn("cbz_taken", 64'hFF0, 1, 1, 0);
      ALUZero = 0;
      txn("cbz_not", 64'hFF4, 1, 0, 0);

      clear_br(); set_rel(64'h1000, 64'h2);
      txn("misalign", EXC_VECTOR, 0, 1, 1);
      clear_br();
      txn("halted", EXC_VECTOR, 0, 0, 1);
      fault_ack = 1;
      txn("ack", EXC_VECTOR, 1, 0, 0);
      fault_ack = 0;
      txn("resume", EXC_VECTOR + 4, 1, 0, 0);

      pc_ready = 0;
      set_rel(64'h200, 64'h100); is_link = 1;
      txn("bl200", 64'h300, 1, 1, 0);
      clear_br(); set_rel(64'h300, 64'h100); is_link = 1;
      txn("bl300", 64'h400, 1, 1, 0);
      clear_br(); set_ret(64'h0);
`ifdef NEXTPC_RAS_EN
      txn("ret1", 64'h304, 1, 1, 0);
      txn("ret2", 64'h204, 1, 1, 0);
`else
      txn("ret1", 64'h0, 1, 1, 0);
      txn("ret2", 64'h0, 1, 1, 0);
`endif
      reg_target = 64'h500;
      txn("ret3", 64'h500, 1, 1, 0);
      for (int i = 0; i <= RAS_DEPTH; i++) begin
         clear_br(); set_rel(64'h1000 + 64'(i * 16), 64'h40); is_link = 1;
         txn("bl_ovf", 64'h1040 + 64'(i * 16), 1, 1, 0);
      end
      for (int i = 0; i <= RAS_DEPTH; i++) begin
         clear_br(); set_ret(64'h700);
         exp = 64'h700;
`ifdef NEXTPC_RAS_EN
         if (i < RAS_DEPTH) exp = 64'h1004 + 64'((RAS_DEPTH - i) * 16);
`endif
         txn("ret_ovf", exp, 1, 1, 0);
      end
      clear_br();

      for (int n = 0; n < 2500; n++) begin
         logic [31:0] r;
         step();
         resetl       = ($urandom_range(0, 149) != 0);
         pc_ready     = ($urandom_range(0, 3) != 0);
         br_valid     = ($urandom_range(0, 2) == 0);
         Branch       = $urandom_range(0, 1);
         ALUZero      = $urandom_range(0, 1);
         Uncondbranch = ($urandom_range(0, 3) == 0);
         BranchReg    = ($urandom_range(0, 3) == 0);
         is_link      = ($urandom_range(0, 2) == 0);
         is_ret       = ($urandom_range(0, 2) == 0);
         fault_ack    = ($urandom_range(0, 3) == 0);
         br_pc        = {$urandom, $urandom} & ~64'h3;
         r            = $urandom;
         SignExtImm   = {{48{r[15]}}, r[15:0]};
         if ($urandom_range(0, 7) != 0) SignExtImm[1:0] = 2'b00;
         reg_target   = {32'h0, $urandom};
         if ($urandom_range(0, 7) != 0) reg_target[1:0] = 2'b00;
      end
      resetl = 1; clear_br();
      repeat (3) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_nextpc_unit
